// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port, word-indexed data memory between two
// requesters (A: CPU load/store path, B: loader/debug).
//
// Every access goes IDLE -> ACCESS -> RESP, so one access takes at least
// three cycles. Stores are steered onto byte lanes (sb/sh/sw). Loads are
// taken from the addressed lane and sign- or zero-extended (lb/lh/lw/lbu/lhu).
//
// Handshake: a requester raises req with its we/funct3/addr/wdata and holds
// them until it sees ack. ack is a one-cycle pulse, and err/rdata are valid
// only while ack is high. A req still high during RESP is ignored. The
// requester drops req in the cycle after ack; otherwise it is taken as a new
// request.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   a_req/a_we/a_funct3/a_addr/a_wdata   port A request
//   a_ack/a_err/a_rdata              port A response
//   b_*                              port B, same as port A
//   mem_wr_en/mem_byte_en/mem_addr/mem_wr_data  memory write side
//   mem_rd_data                      combinational read data for mem_addr
//
// Configuration macro: DMEM_ARB_FIXED_PRIO_EN
//   defined   -> port A always wins simultaneous requests
//   undefined -> round-robin on last_grant
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        a_req,
  input  logic                        a_we,
  input  logic [2:0]                  a_funct3,
  input  logic [ADDR_WIDTH-1:0]       a_addr,
  input  logic [DATA_WIDTH-1:0]       a_wdata,
  output logic                        a_ack,
  output logic                        a_err,
  output logic [DATA_WIDTH-1:0]       a_rdata,
  input  logic                        b_req,
  input  logic                        b_we,
  input  logic [2:0]                  b_funct3,
  input  logic [ADDR_WIDTH-1:0]       b_addr,
  input  logic [DATA_WIDTH-1:0]       b_wdata,
  output logic                        b_ack,
  output logic                        b_err,
  output logic [DATA_WIDTH-1:0]       b_rdata,
  output logic                        mem_wr_en,
  output logic [3:0]                  mem_byte_en,
  output logic [$clog2(MEM_SIZE)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wr_data,
  input  logic [DATA_WIDTH-1:0]       mem_rd_data
);

  localparam int MAW = $clog2(MEM_SIZE);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state, state_nx;
  logic                  gnt;        // 0 = A, 1 = B
  logic                  l_we;
  logic [2:0]            l_f3;
  logic [MAW+1:0]        l_addr;     // word index plus byte offset
  logic [DATA_WIDTH-1:0] l_wdata;
  logic                  l_err;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Request selection
  logic                  grant_b;
  logic                  sel_we;
  logic [2:0]            sel_f3;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  always_comb grant_b = b_req && !a_req;
`else
  logic last_grant;  // 0 = A, 1 = B
  // On a tie, grant the port that was not granted last time.
  always_comb grant_b = b_req && (!a_req || !last_grant);
`endif

  always_comb begin
    sel_we    = grant_b ? b_we     : a_we;
    sel_f3    = grant_b ? b_funct3 : a_funct3;
    sel_addr  = grant_b ? b_addr   : a_addr;
    sel_wdata = grant_b ? b_wdata  : a_wdata;
  end

  // An errored access never writes memory and returns rdata = 0.
  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [ADDR_WIDTH-1:0] addr);
    logic bad_f3, misal, oor;
    bad_f3 = 1'b0;
    misal  = 1'b0;
    case (f3)
      3'b000: misal = 1'b0;
      3'b001: misal = addr[0];
      3'b010: misal = |addr[1:0];
      3'b100: bad_f3 = we;
      3'b101: begin
        bad_f3 = we;
        misal  = addr[0];
      end
      default: bad_f3 = 1'b1;
    endcase
    oor = addr[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(MEM_SIZE);
    return bad_f3 | misal | oor;
  endfunction

  // Load: shift the addressed lane down to bit 0, then extend it.
  logic [31:0] lane;
  logic [31:0] load_val;
  always_comb begin
    lane     = mem_rd_data >> {l_addr[1:0], 3'b000};
    load_val = '0;
    case (l_f3)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b010:  load_val = lane;
      3'b100:  load_val = {24'h0, lane[7:0]};
      3'b101:  load_val = {16'h0, lane[15:0]};
      default: load_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= 1'b0;
      l_we    <= 1'b0;
      l_f3    <= '0;
      l_addr  <= '0;
      l_wdata <= '0;
      l_err   <= 1'b0;
      rdata_q <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;  // B, so A wins the first tie
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            gnt     <= grant_b;
            l_we    <= sel_we;
            l_f3    <= sel_f3;
            l_addr  <= sel_addr[MAW+1:0];
            l_wdata <= sel_wdata;
            l_err   <= access_err(sel_we, sel_f3, sel_addr);
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_grant <= grant_b;
`endif
          end
        end
        ACCESS: rdata_q <= (!l_we && !l_err) ? load_val : '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx    = state;
    mem_wr_en   = 1'b0;
    mem_byte_en = 4'b0000;
    mem_addr    = '0;
    mem_wr_data = '0;
    a_ack       = 1'b0;
    a_err       = 1'b0;
    a_rdata     = '0;
    b_ack       = 1'b0;
    b_err       = 1'b0;
    b_rdata     = '0;
    case (state)
      IDLE: if (a_req || b_req) state_nx = ACCESS;
      ACCESS: begin
        state_nx = RESP;
        mem_addr = l_addr[MAW+1:2];
        if (l_we && !l_err) begin
          mem_wr_en = 1'b1;
          // Replicate narrow data on every lane; byte_en picks the live one.
          case (l_f3)
            3'b000: begin
              mem_byte_en = 4'b0001 << l_addr[1:0];
              mem_wr_data = {4{l_wdata[7:0]}};
            end
            3'b001: begin
              mem_byte_en = 4'b0011 << l_addr[1:0];
              mem_wr_data = {2{l_wdata[15:0]}};
            end
            default: begin
              mem_byte_en = 4'b1111;
              mem_wr_data = l_wdata;
            end
          endcase
        end
      end
      RESP: begin
        state_nx = IDLE;
        if (!gnt) begin
          a_ack   = 1'b1;
          a_err   = l_err;
          a_rdata = rdata_q;
        end else begin
          b_ack   = 1'b1;
          b_err   = l_err;
          b_rdata = rdata_q;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [2:0]  a_funct3, b_funct3;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_ack, a_err, b_ack, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_wr_en;
  logic [3:0]  mem_byte_en;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wr_data, mem_rd_data;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_funct3(a_funct3), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_funct3(b_funct3), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .mem_wr_en(mem_wr_en), .mem_byte_en(mem_byte_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  // ---------------- memory attached to the DUT ----------------
  logic [31:0] mem [0:63];
  logic        mem_load;
  int unsigned mem_seed;

  function automatic logic [31:0] seed_word(input int w);
    return (w * 32'h9E3779B1) ^ mem_seed;
  endfunction

  always @(posedge clk) begin
    if (mem_load) begin
      for (int w = 0; w < 64; w++) mem[w] <= seed_word(w);
    end else if (mem_wr_en) begin
      for (int k = 0; k < 4; k++)
        if (mem_byte_en[k]) mem[mem_addr][8*k +: 8] <= mem_wr_data[8*k +: 8];
    end
  end
  assign mem_rd_data = mem[mem_addr];

  // ---------------- reference model: flat byte array ----------------
  logic [7:0] ref_b [0:255];

  function automatic logic [31:0] ref_word(input int w);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[8*k +: 8] = ref_b[4*w + k];
    return v;
  endfunction

  // Returns {err, rdata} and applies a successful store to ref_b.
  function automatic logic [32:0] model(input logic we, input logic [2:0] f3,
                                        input logic [31:0] addr, input logic [31:0] wdata);
    int size;
    bit ok, sgn;
    logic [31:0] val;
    ok = 1; sgn = 0; size = 1;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: begin size = 1; ok = !we; end
      3'd5: begin size = 2; ok = !we; end
      default: ok = 0;
    endcase
    if (addr % size != 0) ok = 0;
    if (addr / 4 >= 64) ok = 0;
    if (!ok) return {1'b1, 32'h0};
    if (we) begin
      for (int i = 0; i < size; i++) ref_b[addr + i] = wdata[8*i +: 8];
      return {1'b0, 32'h0};
    end
    val = 32'h0;
    for (int i = 0; i < size; i++) val[8*i +: 8] = ref_b[addr + i];
    if (sgn && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
    return {1'b0, val};
  endfunction

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [32:0] exp_a_q[$];
  logic [32:0] exp_b_q[$];
  int          ack_log[$];  // 0 = A, 1 = B, in completion order
  int          ack_cyc[$];
  int          wr_count = 0;
  logic [3:0]  last_be;
  logic [5:0]  last_waddr;
  logic [31:0] last_wdata, last_a_rdata, last_b_rdata;
  logic        last_a_err, last_b_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (mem_wr_en) begin
      wr_count++;
      last_be    = mem_byte_en;
      last_waddr = mem_addr;
      last_wdata = mem_wr_data;
    end
    if (a_ack) begin
      chk("b_quiet_during_a_ack", {b_ack, b_err, b_rdata}, 0);
      ack_log.push_back(0);
      ack_cyc.push_back(cyc);
      last_a_err   = a_err;
      last_a_rdata = a_rdata;
      if (exp_a_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_ack: got ack expected none");
      end else begin
        e = exp_a_q.pop_front();
        chk("a_resp", {a_err, a_rdata}, e);
      end
    end
    if (b_ack) begin
      chk("a_quiet_during_b_ack", {a_ack, a_err, a_rdata}, 0);
      ack_log.push_back(1);
      ack_cyc.push_back(cyc);
      last_b_err   = b_err;
      last_b_rdata = b_rdata;
      if (exp_b_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_ack: got ack expected none");
      end else begin
        e = exp_b_q.pop_front();
        chk("b_resp", {b_err, b_rdata}, e);
      end
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic do_a(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, output int lat);
    exp_a_q.push_back(model(we, f3, addr, wdata));
    a_we = we; a_funct3 = f3; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
    lat = 0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (a_ack) break;
    end
    if (!a_ack) begin
      checks++; errors++;
      $display("FAIL a_timeout: got no ack expected ack within 60 cycles");
      a_req = 1'b0;
      return;
    end
    @(posedge clk);
    #1 a_req = 1'b0;
  endtask

  task automatic do_b(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, output int lat);
    exp_b_q.push_back(model(we, f3, addr, wdata));
    b_we = we; b_funct3 = f3; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
    lat = 0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (b_ack) break;
    end
    if (!b_ack) begin
      checks++; errors++;
      $display("FAIL b_timeout: got no ack expected ack within 60 cycles");
      b_req = 1'b0;
      return;
    end
    @(posedge clk);
    #1 b_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic rand_op(input int base, output logic we, output logic [2:0] f3,
                         output logic [31:0] addr, output logic [31:0] wdata);
    int word, off;
    we    = 1'($urandom_range(0, 1));
    f3    = 3'($urandom_range(0, 7));
    word  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(64, 100))
                                        : base + int'($urandom_range(0, 31));
    off   = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, 3));
    addr  = 32'(word * 4 + off);
    wdata = $urandom;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, wc0;
    logic [31:0] w;
    a_req = 0; a_we = 0; a_funct3 = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_funct3 = 0; b_addr = 0; b_wdata = 0;
    rst_n = 1'b0;
    mem_load = 1'b1;
    mem_seed = $urandom;
    for (int i = 0; i < 64; i++) begin
      w = seed_word(i);
      for (int k = 0; k < 4; k++) ref_b[4*i + k] = w[8*k +: 8];
    end
    @(posedge clk);
    #1 mem_load = 1'b0;
    chk("reset_a_outputs", {a_ack, a_err, a_rdata}, 0);
    chk("reset_b_outputs", {b_ack, b_err, b_rdata}, 0);
    chk("reset_mem_outputs", {mem_wr_en, mem_byte_en, mem_addr, mem_wr_data}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: word store and reload
    wc0 = wr_count;
    do_a(1, 3'b010, 32'h08, 32'hDEADBEEF, lat);
    chk("t1_latency", lat, 3);
    chk("t1_wr_count", wr_count, wc0 + 1);
    chk("t1_write", {last_be, last_waddr, last_wdata}, {4'b1111, 6'd2, 32'hDEADBEEF});
    do_a(0, 3'b010, 32'h08, 0, lat);
    chk("t1_lw_value", last_a_rdata, 32'hDEADBEEF);

    // 2: byte store into a known word, then byte loads
    do_a(1, 3'b010, 32'h0C, 32'h11223344, lat);
    do_a(1, 3'b000, 32'h0D, 32'h000000A5, lat);
    chk("t2_sb_lanes", {last_be, last_waddr, last_wdata}, {4'b0010, 6'd3, 32'hA5A5A5A5});
    chk("t2_word", mem[3], 32'h1122A544);
    do_a(0, 3'b000, 32'h0D, 0, lat);
    chk("t2_lb", last_a_rdata, 32'hFFFFFFA5);
    do_a(0, 3'b100, 32'h0D, 0, lat);
    chk("t2_lbu", last_a_rdata, 32'h000000A5);

    // 4: errors
    wc0 = wr_count;
    do_a(1, 3'b010, 32'h06, 32'h12345678, lat);
    chk("t4_sw_mis_err", last_a_err, 1);
    chk("t4_no_write", wr_count, wc0);
    do_a(0, 3'b101, 32'h03, 0, lat);
    chk("t4_lhu_mis", {last_a_err, last_a_rdata}, {1'b1, 32'h0});
    do_a(0, 3'b010, 32'h100, 0, lat);
    chk("t4_lw_oor", {last_a_err, last_a_rdata}, {1'b1, 32'h0});
    do_a(1, 3'b011, 32'h10, 32'h1, lat);
    chk("t4_bad_f3_store", last_a_err, 1);
    chk("t4_no_write_total", wr_count, wc0);

    // 5: port B halfword loads
    do_b(1, 3'b010, 32'h10, 32'h80017FFF, lat);
    chk("t5_b_latency", lat, 3);
    do_b(0, 3'b001, 32'h12, 0, lat);
    chk("t5_lh", {last_b_err, last_b_rdata}, {1'b0, 32'hFFFF8001});
    do_b(0, 3'b101, 32'h12, 0, lat);
    chk("t5_lhu", last_b_rdata, 32'h00008001);

    // 3: both ports requesting continuously from reset
    do_reset();
    ack_log.delete();
    ack_cyc.delete();
    fork
      begin int l; for (int i = 0; i < 4; i++) do_a(0, 3'b010, 32'(32'h20 + 4*i), 0, l); end
      begin int l; for (int i = 0; i < 2; i++) do_b(0, 3'b010, 32'(32'h80 + 4*i), 0, l); end
    join
    chk("t3_ack_count", ack_log.size(), 6);
    if (ack_log.size() == 6) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      int exp_order[6] = '{0, 0, 0, 0, 1, 1};
`else
      int exp_order[6] = '{0, 1, 0, 1, 0, 0};
`endif
      for (int i = 0; i < 6; i++) chk("t3_grant_order", ack_log[i], exp_order[i]);
      for (int i = 1; i < 6; i++) chk("t3_ack_spacing", ack_cyc[i] - ack_cyc[i-1], 3);
    end

    // 6: reset during the ACCESS cycle of a store
    a_we = 1; a_funct3 = 3'b010; a_addr = 32'h24; a_wdata = 32'hCAFEF00D; a_req = 1'b1;
    @(posedge clk);
    #1 chk("t6_wr_en_in_access", {mem_wr_en, mem_addr}, {1'b1, 6'd9});
    #1 rst_n = 1'b0;
    #1 chk("t6_wr_en_drops", mem_wr_en, 0);
    a_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_ack", {a_ack, b_ack}, 0);
    end
    chk("t6_mem_unchanged", mem[9], ref_word(9));
    @(posedge clk);
    #1 ack_log.delete();
    fork
      begin int l; do_a(0, 3'b010, 32'h24, 0, l); chk("t6_a_latency", l, 3); end
      begin int l; do_b(0, 3'b010, 32'h84, 0, l); end
    join
    chk("t6_tie_count", ack_log.size(), 2);
    if (ack_log.size() == 2) chk("t6_a_wins_tie", ack_log[0], 0);

    // random traffic: A uses words 0..31, B words 32..63 (plus out-of-range)
    fork
      begin
        int l; logic we; logic [2:0] f3; logic [31:0] ad, wd;
        for (int i = 0; i < 40; i++) begin
          rand_op(0, we, f3, ad, wd);
          do_a(we, f3, ad, wd, l);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
      begin
        int l; logic we; logic [2:0] f3; logic [31:0] ad, wd;
        for (int i = 0; i < 40; i++) begin
          rand_op(32, we, f3, ad, wd);
          do_b(we, f3, ad, wd, l);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
    join

    repeat (3) @(posedge clk);
    chk("drain_a", exp_a_q.size(), 0);
    chk("drain_b", exp_b_q.size(), 0);
    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_word(i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
